// File: rtl/ddr_rd_pkg.sv
// Shared types and defaults for the DDR read engine.
//   state_e     : engine FSM states
//   *_DEF       : default widths for address, length and data
//   BL_W        : width of the DDR native burst-length field
package ddr_rd_pkg;

    localparam int unsigned ADDR_W_DEF = 25;
    localparam int unsigned LEN_W_DEF  = 10;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned BL_W       = 9;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_e;

endpackage

// File: rtl/ddr_rd_ctrl_if.sv
// DDR native read port: command channel plus returned read beats.
//   cmd_en/cmd_addr/cmd_bl : read command, accepted when cmd_en & cmd_rdy
//   rd_valid/rd_data       : returned read beats
// master: the read engine; slave: the DDR controller.
interface ddr_rd_ctrl_if #(
    parameter int ADDR_W = ddr_rd_pkg::ADDR_W_DEF,
    parameter int DATA_W = ddr_rd_pkg::DATA_W_DEF
) ();

    logic                         cmd_en;
    logic [ADDR_W-1:0]            cmd_addr;
    logic [ddr_rd_pkg::BL_W-1:0]  cmd_bl;
    logic                         cmd_rdy;
    logic                         rd_valid;
    logic [DATA_W-1:0]            rd_data;

    modport master (
        output cmd_en, cmd_addr, cmd_bl,
        input  cmd_rdy, rd_valid, rd_data
    );

    modport slave (
        input  cmd_en, cmd_addr, cmd_bl,
        output cmd_rdy, rd_valid, rd_data
    );

endinterface

// File: rtl/ddr_rd_burst_calc.sv
// Burst bookkeeping for the read engine: holds the words still to request and the
// next burst address, and sizes each burst as min(remaining, MAX_BURST).
//   ddr_clk, sys_rst : clock, synchronous active-high reset
//   load             : capture load_addr/load_len (request accepted)
//   step             : a burst of burst_len words was issued; advance
//   remaining        : words not yet requested
//   cur_addr         : start address of the next burst (wraps at 2^ADDR_W)
//   burst_len        : length of the next burst
module ddr_rd_burst_calc import ddr_rd_pkg::*; #(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          LEN_W     = LEN_W_DEF,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic              ddr_clk,
    input  logic              sys_rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              step,
    output logic [LEN_W-1:0]  remaining,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [BL_W-1:0]   burst_len
);

    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;

    // Compare at 32 bits so a MAX_BURST wider than LEN_W cannot truncate.
    always_comb begin
        if (32'(remaining_q) > MAX_BURST) begin
            burst_len = BL_W'(MAX_BURST);
        end else begin
            burst_len = BL_W'(remaining_q);
        end
    end

    always_comb begin
        remaining_d = remaining_q;
        cur_addr_d  = cur_addr_q;
        if (load) begin
            remaining_d = load_len;
            cur_addr_d  = load_addr;
        end else if (step) begin
            remaining_d = remaining_q - LEN_W'(burst_len);
            cur_addr_d  = cur_addr_q + ADDR_W'(burst_len);
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (sys_rst) begin
            remaining_q <= '0;
            cur_addr_q  <= '0;
        end else begin
            remaining_q <= remaining_d;
            cur_addr_q  <= cur_addr_d;
        end
    end

    assign remaining = remaining_q;
    assign cur_addr  = cur_addr_q;

endmodule

// File: rtl/ddr_rd_ctrl.sv
// DDR read engine behind the read arbiter. Takes one granted read (address + length),
// splits it into bursts of at most MAX_BURST words, forwards every returned beat to the
// granted slave's write FIFO, and pulses ddr_read_finish once the request is delivered.
//   ddr_clk, sys_rst            : clock, synchronous active-high reset
//   ready, mem_ren,
//   mem_ren_valid               : idle flag, request, 1-cycle accept pulse
//   arb_rddr_addr, arb_rddr_len : request start word address and length
//   ddr_Wfifo_en/_data          : forwarded beats (1-cycle latency from rd_valid)
//   ddr_read_finish             : 1-cycle completion pulse
//   ddr (master)                : DDR native command/read port
//   rd_err                      : sticky watchdog timeout flag
// Build option: define DDR_RD_TIMEOUT_EN to add the watchdog; otherwise rd_err is 0 and
// the engine waits indefinitely on the DDR.
module ddr_rd_ctrl import ddr_rd_pkg::*; #(
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          LEN_W     = LEN_W_DEF,
    parameter int          DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              ddr_clk,
    input  logic              sys_rst,
    output logic              ready,
    input  logic              mem_ren,
    output logic              mem_ren_valid,
    input  logic [ADDR_W-1:0] arb_rddr_addr,
    input  logic [LEN_W-1:0]  arb_rddr_len,
    output logic              ddr_Wfifo_en,
    output logic [DATA_W-1:0] ddr_Wfifo_data,
    output logic              ddr_read_finish,
    ddr_rd_ctrl_if.master     ddr,
    output logic              rd_err
);

    if (MAX_BURST < 1 || MAX_BURST > 256 || (MAX_BURST & (MAX_BURST - 1)) != 0 ||
        TIMEOUT < 2) begin : g_bad_param
        $error("ddr_rd_ctrl: MAX_BURST must be a power of two in 1..256, TIMEOUT >= 2");
    end

    state_e              state_q, state_d;
    logic [BL_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                wfifo_en_q;
    logic [DATA_W-1:0]   wfifo_data_q;
    logic                finish_q;

    logic                accept, cmd_fire, beat_fire, abort;
    logic [LEN_W-1:0]    remaining;
    logic [ADDR_W-1:0]   cur_addr;
    logic [BL_W-1:0]     burst_len;

    assign accept    = (state_q == IDLE) && mem_ren;
    assign cmd_fire  = (state_q == CMD) && ddr.cmd_rdy;
    // Beats outside DATA are not ours and are dropped.
    assign beat_fire = (state_q == DATA) && ddr.rd_valid;

    ddr_rd_burst_calc #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .ddr_clk   (ddr_clk),
        .sys_rst   (sys_rst),
        .load      (accept),
        .load_addr (arb_rddr_addr),
        .load_len  (arb_rddr_len),
        .step      (cmd_fire),
        .remaining (remaining),
        .cur_addr  (cur_addr),
        .burst_len (burst_len)
    );

`ifdef DDR_RD_TIMEOUT_EN
    localparam int unsigned WDOG_W = $clog2(TIMEOUT + 1);

    logic [WDOG_W-1:0] wdog_q;
    logic              rd_err_q;
    logic              busy, progress;

    assign busy     = (state_q == CMD) || (state_q == DATA);
    assign progress = cmd_fire || beat_fire;
    // Trip on the TIMEOUT-th consecutive cycle without progress.
    assign abort    = busy && !progress && (wdog_q == WDOG_W'(TIMEOUT - 1));

    always_ff @(posedge ddr_clk) begin
        if (sys_rst) begin
            wdog_q   <= '0;
            rd_err_q <= 1'b0;
        end else begin
            if (!busy || progress) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_q + WDOG_W'(1);
            end
            if (abort) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    assign rd_err = rd_err_q;
`else
    assign abort  = 1'b0;
    assign rd_err = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        ready         = 1'b0;
        mem_ren_valid = 1'b0;
        ddr.cmd_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (mem_ren) begin
                    mem_ren_valid = 1'b1;
                    state_d       = (arb_rddr_len == '0) ? DONE : CMD;
                end
            end
            CMD: begin
                ddr.cmd_en = 1'b1;
                if (abort) begin
                    state_d = DONE;
                end else if (ddr.cmd_rdy) begin
                    beat_cnt_d = burst_len;
                    state_d    = DATA;
                end
            end
            DATA: begin
                if (abort) begin
                    state_d = DONE;
                end else if (ddr.rd_valid) begin
                    beat_cnt_d = beat_cnt_q - BL_W'(1);
                    if (beat_cnt_q == BL_W'(1)) begin
                        state_d = (remaining != '0) ? CMD : DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address/length are only meaningful while cmd_en is high; hold them at 0 otherwise.
    assign ddr.cmd_addr = (state_q == CMD) ? cur_addr : '0;
    assign ddr.cmd_bl   = (state_q == CMD) ? burst_len : '0;

    always_ff @(posedge ddr_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            wfifo_en_q   <= 1'b0;
            wfifo_data_q <= '0;
            finish_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wfifo_en_q <= beat_fire;
            if (beat_fire) begin
                wfifo_data_q <= ddr.rd_data;
            end
            // Registered so the pulse lands the cycle after the last forwarded beat.
            finish_q <= (state_q == DONE);
        end
    end

    assign ddr_Wfifo_en    = wfifo_en_q;
    assign ddr_Wfifo_data  = wfifo_data_q;
    assign ddr_read_finish = finish_q;

endmodule

// File: tb/tb_ddr_rd_ctrl.sv
// Bench for ddr_rd_ctrl: a DDR responder returns random beats for every accepted command;
// expected commands are queued when a request is issued and expected beats when they are
// driven, and both are popped and compared as the DUT produces them.
module tb_ddr_rd_ctrl;

    localparam int ADDR_W    = 25;
    localparam int LEN_W     = 10;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 64;
    localparam int TIMEOUT   = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [8:0]        bl;
    } cmd_t;

    logic              ddr_clk = 1'b0;
    logic              sys_rst;
    logic              ready;
    logic              mem_ren;
    logic              mem_ren_valid;
    logic [ADDR_W-1:0] arb_rddr_addr;
    logic [LEN_W-1:0]  arb_rddr_len;
    logic              ddr_Wfifo_en;
    logic [DATA_W-1:0] ddr_Wfifo_data;
    logic              ddr_read_finish;
    logic              rd_err;

    ddr_rd_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ddr ();

    ddr_rd_ctrl #(
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .ddr_clk         (ddr_clk),
        .sys_rst         (sys_rst),
        .ready           (ready),
        .mem_ren         (mem_ren),
        .mem_ren_valid   (mem_ren_valid),
        .arb_rddr_addr   (arb_rddr_addr),
        .arb_rddr_len    (arb_rddr_len),
        .ddr_Wfifo_en    (ddr_Wfifo_en),
        .ddr_Wfifo_data  (ddr_Wfifo_data),
        .ddr_read_finish (ddr_read_finish),
        .ddr             (ddr),
        .rd_err          (rd_err)
    );

    always #5 ddr_clk = ~ddr_clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc = 0;
    int beats_seen = 0;
    int finish_seen = 0;
    int last_wfifo_cyc = 0;
    int finish_cyc = 0;
    int acc_cyc = 0;
    int b0 = 0;
    int f0 = 0;

    bit resp_en   = 1'b1;
    bit gaps      = 1'b0;
    bit rdy_rand  = 1'b0;
    bit rdy_level = 1'b1;
    bit stray     = 1'b0;

    cmd_t              exp_cmd_q[$];
    logic [DATA_W-1:0] beat_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic [DATA_W-1:0] drv_d;

    bit                prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr;
    logic [8:0]        prev_bl;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge ddr_clk) cyc <= cyc + 1;

    // DDR responder: sole driver of cmd_rdy/rd_valid/rd_data.
    always @(posedge ddr_clk) begin
        #1;
        ddr.cmd_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
        if (resp_en && beat_q.size() != 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            drv_d        = beat_q.pop_front();
            ddr.rd_valid = 1'b1;
            ddr.rd_data  = drv_d;
            exp_data_q.push_back(drv_d);
        end else begin
            ddr.rd_valid = resp_en ? 1'b0 : stray;
            ddr.rd_data  = 32'hDEAD_BEEF;
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge ddr_clk) begin
        if (ddr_Wfifo_en) begin
            if (exp_data_q.size() == 0) begin
                check_eq("wfifo_unexpected", 64'(ddr_Wfifo_en), 64'd0);
            end else begin
                check_eq("wfifo_data", 64'(ddr_Wfifo_data), 64'(exp_data_q.pop_front()));
            end
            beats_seen++;
            last_wfifo_cyc = cyc;
        end
        if (ddr_read_finish) begin
            finish_seen++;
            finish_cyc = cyc;
        end
        if (prev_stall && !sys_rst) begin
            check_eq("stall_cmd_en", 64'(ddr.cmd_en), 64'd1);
            check_eq("stall_cmd_addr", 64'(ddr.cmd_addr), 64'(prev_addr));
            check_eq("stall_cmd_bl", 64'(ddr.cmd_bl), 64'(prev_bl));
        end
        prev_stall = ddr.cmd_en && !ddr.cmd_rdy && !sys_rst;
        prev_addr  = ddr.cmd_addr;
        prev_bl    = ddr.cmd_bl;
        if (ddr.cmd_en && ddr.cmd_rdy) begin
            if (exp_cmd_q.size() == 0) begin
                check_eq("cmd_unexpected", 64'(ddr.cmd_en), 64'd0);
            end else begin
                cmd_t e;
                e = exp_cmd_q.pop_front();
                check_eq("cmd_addr", 64'(ddr.cmd_addr), 64'(e.addr));
                check_eq("cmd_bl", 64'(ddr.cmd_bl), 64'(e.bl));
                for (int i = 0; i < int'(e.bl); i++) beat_q.push_back($urandom);
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ddr_clk);
            #1;
        end
    endtask

    task automatic push_cmds(input logic [ADDR_W-1:0] a, input int len);
        logic [ADDR_W-1:0] ad;
        int r;
        int bl;
        cmd_t c;
        ad = a;
        r  = len;
        while (r > 0) begin
            bl = (r > MAX_BURST) ? MAX_BURST : r;
            c.addr = ad;
            c.bl   = 9'(bl);
            exp_cmd_q.push_back(c);
            ad = ad + ADDR_W'(bl);
            r  = r - bl;
        end
    endtask

    task automatic start_req(input logic [ADDR_W-1:0] a, input int len);
        int w;
        w = 0;
        tick(1);
        while (!ready && w < 200) begin
            tick(1);
            w++;
        end
        check_eq("ready_before_req", 64'(ready), 64'd1);
        push_cmds(a, len);
        b0 = beats_seen;
        f0 = finish_seen;
        mem_ren       = 1'b1;
        arb_rddr_addr = a;
        arb_rddr_len  = LEN_W'(len);
        #1;
        check_eq("mem_ren_valid", 64'(mem_ren_valid), 64'd1);
        acc_cyc = cyc;
        @(posedge ddr_clk);
        #1;
        mem_ren = 1'b0;
    endtask

    task automatic wait_done(input int len, input int budget);
        int n;
        n = 0;
        while (finish_seen == f0 && n < budget) begin
            tick(1);
            n++;
        end
        check_eq("finish_seen", 64'(finish_seen - f0), 64'd1);
        check_eq("ready_at_finish", 64'(ready), 64'd1);
        if (len > 0) begin
            check_eq("finish_after_last_beat", 64'(finish_cyc - last_wfifo_cyc), 64'd1);
        end else begin
            check_eq("finish_latency_len0", 64'(finish_cyc - acc_cyc), 64'd2);
        end
        tick(3);
        check_eq("beat_count", 64'(beats_seen - b0), 64'(len));
        check_eq("finish_once", 64'(finish_seen - f0), 64'd1);
        check_eq("cmds_left", 64'(exp_cmd_q.size()), 64'd0);
        check_eq("data_left", 64'(exp_data_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int n;
        int b1;
        int f1;
        sys_rst       = 1'b1;
        mem_ren       = 1'b0;
        arb_rddr_addr = '0;
        arb_rddr_len  = '0;
        tick(3);
        check_eq("rst_ready", 64'(ready), 64'd1);
        check_eq("rst_mem_ren_valid", 64'(mem_ren_valid), 64'd0);
        check_eq("rst_cmd_en", 64'(ddr.cmd_en), 64'd0);
        check_eq("rst_cmd_addr", 64'(ddr.cmd_addr), 64'd0);
        check_eq("rst_cmd_bl", 64'(ddr.cmd_bl), 64'd0);
        check_eq("rst_wfifo_en", 64'(ddr_Wfifo_en), 64'd0);
        check_eq("rst_finish", 64'(ddr_read_finish), 64'd0);
        check_eq("rst_rd_err", 64'(rd_err), 64'd0);
        sys_rst = 1'b0;
        tick(2);

        // Single burst, back-to-back data.
        start_req(25'h100, 16);
        wait_done(16, 200);

        // Three bursts with throttled data.
        gaps = 1'b1;
        start_req(25'h0, 130);
        wait_done(130, 1000);

        // Top of address space: one burst, then a request that wraps to low addresses.
        start_req(25'h1FF_FFF0, 32);
        wait_done(32, 400);
        start_req(25'h1FF_FFF0, 130);
        wait_done(130, 1000);

        // Zero length: accepted, no command, finish two cycles after accept.
        start_req(25'h55, 0);
        wait_done(0, 20);

        // Command stalled 20 cycles; a second mem_ren while busy is ignored.
        rdy_level = 1'b0;
        start_req(25'h300, 40);
        mem_ren       = 1'b1;
        arb_rddr_addr = 25'h777;
        arb_rddr_len  = 10'd5;
        tick(20);
        check_eq("busy_mem_ren_valid", 64'(mem_ren_valid), 64'd0);
        check_eq("hold_cmd_en", 64'(ddr.cmd_en), 64'd1);
        check_eq("hold_cmd_addr", 64'(ddr.cmd_addr), 64'h300);
        check_eq("hold_cmd_bl", 64'(ddr.cmd_bl), 64'd40);
        mem_ren   = 1'b0;
        rdy_level = 1'b1;
        wait_done(40, 400);

        // Maximum request with random command back-pressure.
        rdy_rand = 1'b1;
        start_req(25'h1FF_FF00, 1023);
        wait_done(1023, 20000);
        rdy_rand = 1'b0;
        gaps     = 1'b0;

        // Reset in the middle of DATA with a stray rd_valid.
        start_req(25'h200, 64);
        n = 0;
        while (beats_seen - b0 < 10 && n < 500) begin
            tick(1);
            n++;
        end
        resp_en = 1'b0;
        tick(2);
        check_eq("pre_rst_data_left", 64'(exp_data_q.size()), 64'd0);
        b1      = beats_seen;
        f1      = finish_seen;
        stray   = 1'b1;
        sys_rst = 1'b1;
        tick(3);
        check_eq("mid_rst_wfifo_en", 64'(ddr_Wfifo_en), 64'd0);
        sys_rst = 1'b0;
        tick(6);
        stray = 1'b0;
        check_eq("post_rst_beats", 64'(beats_seen - b1), 64'd0);
        check_eq("post_rst_finish", 64'(finish_seen - f1), 64'd0);
        check_eq("post_rst_ready", 64'(ready), 64'd1);
        beat_q.delete();
        exp_cmd_q.delete();
        resp_en = 1'b1;
        tick(2);
        start_req(25'h20, 8);
        wait_done(8, 200);

        // DDR never returns data.
        resp_en = 1'b0;
        start_req(25'h400, 8);
`ifdef DDR_RD_TIMEOUT_EN
        n = 0;
        while (finish_seen == f0 && n < 100) begin
            tick(1);
            n++;
        end
        check_eq("to_finish", 64'(finish_seen - f0), 64'd1);
        check_eq("to_latency_ok",
                 64'((finish_cyc - acc_cyc) >= TIMEOUT && (finish_cyc - acc_cyc) <= TIMEOUT + 8),
                 64'd1);
        tick(3);
        check_eq("to_rd_err", 64'(rd_err), 64'd1);
        check_eq("to_ready", 64'(ready), 64'd1);
        check_eq("to_beats", 64'(beats_seen - b0), 64'd0);
        beat_q.delete();
        resp_en = 1'b1;
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        tick(1);
        check_eq("to_rd_err_cleared", 64'(rd_err), 64'd0);
`else
        tick(60);
        check_eq("wait_no_finish", 64'(finish_seen - f0), 64'd0);
        check_eq("wait_rd_err", 64'(rd_err), 64'd0);
        check_eq("wait_not_ready", 64'(ready), 64'd0);
        resp_en = 1'b1;
        wait_done(8, 200);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
